// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Serial-to-parallel frame receiver. Watches a 1-bit-per-clock stream (idle
// high), detects a start bit (0), assembles WIDTH data bits LSB first,
// optionally checks an even-parity bit, samples the stop bit (1), and then
// presents the word on a single-entry valid/ready buffer. Framing, parity and
// overrun errors are reported as one-cycle registered pulses.
//
// Optional feature macro:
//   SFRX_PARITY_EN  defined   -> PARITY state present; frames carry an even
//                                parity bit after the data; parity_err is live.
//                   undefined -> no parity bit; parity_err is tied 0.
//
// Parameters:
//   WIDTH       data bits per frame (2..32)
//
// Ports:
//   clk         rising-edge clock, one serial bit per cycle
//   rst_n       asynchronous active-low reset
//   sin         serial input stream, idle level 1
//   dout        received word, valid while dvalid=1
//   dvalid      dout holds an unconsumed word
//   dready      consumer accepts dout when dvalid && dready
//   busy        receiver is inside a frame or waiting out a break
//   frame_err   one-cycle pulse: stop bit sampled as 0
//   parity_err  one-cycle pulse: parity mismatch (0 without SFRX_PARITY_EN)
//   overrun     one-cycle pulse: completed word dropped, buffer full
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SFRX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STOP,
    BREAK
  } state_e;
`endif

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] dout_q;
  logic             dvalid_q;
  logic             ferr_q;
  logic             ovr_q;
`ifdef SFRX_PARITY_EN
  logic             perr_flag_q;   // parity failed for the frame in flight
  logic             perr_pulse_q;
`endif

  // A completed word may be written if the buffer is empty or is being
  // drained in this very cycle.
  logic buf_free_d;
  assign buf_free_d = !dvalid_q || dready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  // NOTE: shift_q is a plain register (not a memory array), so it is reset
  // along with everything else at no cost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
`ifdef SFRX_PARITY_EN
      perr_flag_q  <= 1'b0;
      perr_pulse_q <= 1'b0;
`endif
    end else begin
      // Error outputs are single-cycle pulses.
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
`ifdef SFRX_PARITY_EN
      perr_pulse_q <= 1'b0;
`endif

      // Consumer handshake; a delivery in the STOP branch below overrides it.
      if (dvalid_q && dready) begin
        dvalid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_q     <= DATA;
            cnt_q       <= '0;
`ifdef SFRX_PARITY_EN
            perr_flag_q <= 1'b0;
`endif
          end
        end

        DATA: begin
          shift_q[cnt_q] <= sin;
          if (cnt_q == LAST_BIT) begin
`ifdef SFRX_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef SFRX_PARITY_EN
        PARITY: begin
          // Even parity: parity bit equals the XOR of the data bits.
          perr_flag_q <= sin ^ (^shift_q);
          state_q     <= STOP;
        end
`endif

        STOP: begin
          if (sin) begin
            state_q <= IDLE;
`ifdef SFRX_PARITY_EN
            if (perr_flag_q) begin
              perr_pulse_q <= 1'b1;
            end else
`endif
            if (buf_free_d) begin
              dout_q   <= shift_q;
              dvalid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end else begin
            // Bad stop bit wins over a parity failure; wait for line release.
            ferr_q  <= 1'b1;
            state_q <= BREAK;
          end
        end

        BREAK: begin
          if (sin) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout      = dout_q;
  assign dvalid    = dvalid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef SFRX_PARITY_EN
  assign parity_err = perr_pulse_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Directed self-checking bench for serial_frame_rx (WIDTH=8). Inputs change
// 1 time unit after each rising edge and outputs are sampled at that same
// point, so every check sees the result of the edge just taken.
// Parity scenarios are compiled in only when SFRX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             dready;
  logic             busy;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  int n_cmp;
  int n_bad;

  serial_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .dout       (dout),
    .dvalid     (dvalid),
    .dready     (dready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Present one bit, take one rising edge, settle.
  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  // Whole frame; dready is set to rdy just before the stop bit so the bench
  // can control the handshake on the completion edge.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic rdy);
    send_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) send_bit(d[i]);
`ifdef SFRX_PARITY_EN
    send_bit(^d);
`endif
    dready = rdy;
    send_bit(stopb);
  endtask

`ifdef SFRX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par, input logic rdy);
    send_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) send_bit(d[i]);
    send_bit(par);
    dready = rdy;
    send_bit(1'b1);
  endtask
`endif

  task automatic check_idle_out(input string tag);
    check({tag, ".dvalid"},    32'(dvalid),     32'd0);
    check({tag, ".dout"},      32'(dout),       32'd0);
    check({tag, ".busy"},      32'(busy),       32'd0);
    check({tag, ".frame_err"}, 32'(frame_err),  32'd0);
    check({tag, ".par_err"},   32'(parity_err), 32'd0);
    check({tag, ".overrun"},   32'(overrun),    32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    sin    = 1'b1;
    dready = 1'b0;

    // ---------------- reset state ----------------
    #1;
    check_idle_out("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_out("post_reset");

    // ---------------- basic receive 0xA5 ----------------
    dready = 1'b1;
    send_bit(1'b0);                         // start at edge k
    check("a5.busy_k", 32'(busy), 32'd1);
    for (int i = 0; i < WIDTH; i++) send_bit(8'hA5 >> i);
`ifdef SFRX_PARITY_EN
    send_bit(1'b0);                         // ^0xA5 = 0
`endif
    check("a5.dvalid_pre", 32'(dvalid), 32'd0);
    check("a5.busy_pre",   32'(busy),   32'd1);
    send_bit(1'b1);                         // stop at edge S
    check("a5.dvalid", 32'(dvalid),     32'd1);
    check("a5.dout",   32'(dout),       32'hA5);
    check("a5.busy",   32'(busy),       32'd0);
    check("a5.ferr",   32'(frame_err),  32'd0);
    check("a5.perr",   32'(parity_err), 32'd0);
    check("a5.ovr",    32'(overrun),    32'd0);
    send_bit(1'b1);
    check("a5.dvalid_clr", 32'(dvalid), 32'd0);

    // ---------------- back-to-back 0x3C, 0xC3 ----------------
    send_frame(8'h3C, 1'b1, 1'b1);
    check("b2b.dvalid0", 32'(dvalid), 32'd1);
    check("b2b.dout0",   32'(dout),   32'h3C);
    send_bit(1'b0);                         // start right at S+1
    check("b2b.dvalid_drain", 32'(dvalid), 32'd0);
    for (int i = 0; i < WIDTH; i++) send_bit(8'hC3 >> i);
`ifdef SFRX_PARITY_EN
    send_bit(1'b0);                         // ^0xC3 = 0
`endif
    check("b2b.dvalid_pre1", 32'(dvalid), 32'd0);
    send_bit(1'b1);
    check("b2b.dvalid1", 32'(dvalid), 32'd1);
    check("b2b.dout1",   32'(dout),   32'hC3);
    send_bit(1'b1);

    // ---------------- framing error on 0x5A ----------------
    send_frame(8'h5A, 1'b0, 1'b1);
    check("ferr.pulse",  32'(frame_err), 32'd1);
    check("ferr.dvalid", 32'(dvalid),    32'd0);
    check("ferr.busy",   32'(busy),      32'd1);
    send_bit(1'b0);
    check("ferr.pulse_end", 32'(frame_err), 32'd0);
    check("ferr.break1",    32'(busy),      32'd1);
    send_bit(1'b0);
    check("ferr.break2",    32'(busy),      32'd1);
    check("ferr.dvalid2",   32'(dvalid),    32'd0);
    send_bit(1'b1);
    check("ferr.released",  32'(busy),      32'd0);
    send_frame(8'h81, 1'b1, 1'b1);
    check("ferr.next_dvalid", 32'(dvalid), 32'd1);
    check("ferr.next_dout",   32'(dout),   32'h81);
    send_bit(1'b1);

    // ---------------- overrun ----------------
    dready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr.dvalid0", 32'(dvalid),  32'd1);
    check("ovr.dout0",   32'(dout),    32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ovr.pulse",   32'(overrun), 32'd1);
    check("ovr.dout",    32'(dout),    32'h11);
    check("ovr.dvalid",  32'(dvalid),  32'd1);
    send_bit(1'b1);
    check("ovr.pulse_end", 32'(overrun), 32'd0);
    check("ovr.held",      32'(dvalid),  32'd1);
    dready = 1'b1;
    send_bit(1'b1);
    check("ovr.drained", 32'(dvalid), 32'd0);

    // ---------------- accept on completion edge ----------------
    dready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    check("acc.dout0", 32'(dout), 32'h11);
    send_frame(8'h22, 1'b1, 1'b1);          // dready=1 only at stop edge
    check("acc.dout",   32'(dout),    32'h22);
    check("acc.dvalid", 32'(dvalid),  32'd1);
    check("acc.ovr",    32'(overrun), 32'd0);
    send_bit(1'b1);
    check("acc.drained", 32'(dvalid), 32'd0);

    // ---------------- reset mid-frame ----------------
    dready = 1'b0;
    send_frame(8'h33, 1'b1, 1'b0);
    check("rst.pre_dvalid", 32'(dvalid), 32'd1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(8'h66 >> i);
    check("rst.busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_out("rst.async");
    sin = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst.idle", 32'(busy), 32'd0);
    send_frame(8'hFF, 1'b1, 1'b1);
    check("rst.ff_dvalid", 32'(dvalid),    32'd1);
    check("rst.ff_dout",   32'(dout),      32'hFF);
    check("rst.ff_ferr",   32'(frame_err), 32'd0);
    send_bit(1'b1);
    check("rst.ff_drained", 32'(dvalid), 32'd0);

`ifdef SFRX_PARITY_EN
    // ---------------- parity ----------------
    send_frame_par(8'h07, 1'b0, 1'b1);
    check("par.bad_pulse",  32'(parity_err), 32'd1);
    check("par.bad_dvalid", 32'(dvalid),     32'd0);
    check("par.bad_ferr",   32'(frame_err),  32'd0);
    send_bit(1'b1);
    check("par.pulse_end",  32'(parity_err), 32'd0);
    send_frame_par(8'h07, 1'b1, 1'b1);
    check("par.ok_dvalid",  32'(dvalid),     32'd1);
    check("par.ok_dout",    32'(dout),       32'h07);
    check("par.ok_perr",    32'(parity_err), 32'd0);
    send_bit(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
